// File: rtl/fir_pkg.sv
// Shared constants for the 8-tap FIR: tap count, output shift, coefficients.
package fir_pkg;
  localparam int NUM_TAPS = 8;
  localparam int SHIFT    = 8;
  localparam int unsigned COEFS [NUM_TAPS] = '{
    4, 16, 32, 76, 76, 32, 16, 4
  };
endpackage

// File: rtl/fir_tap_line.sv
// Enable-gated shift register with synchronous clear; tap 0 is newest.
module fir_tap_line
  import fir_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                             clock,
  input  logic                             i_clr,
  input  logic                             i_en,
  input  logic [DATA_W-1:0]                i_din,
  output logic [NUM_TAPS-1:0][DATA_W-1:0]  o_taps
);
  logic [NUM_TAPS-1:0][DATA_W-1:0] r_taps;

  always_ff @(posedge clock) begin
    if (i_clr) begin
      r_taps <= '0;
    end else if (i_en) begin
      r_taps <= {r_taps[NUM_TAPS-2:0], i_din};
    end
  end

  assign o_taps = r_taps;
endmodule

// File: rtl/fir_filter.sv
// 8-tap direct-form FIR, products then sum/round pipeline.
// Define FIR_ROUND_EN for round-half-up instead of truncation.
module fir_filter
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = DATA_W + COEF_W + 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vin,
  input  logic [DATA_W-1:0] din,
  output logic              vout,
  output logic [DATA_W-1:0] dout
);
  localparam int PROD_W = DATA_W + COEF_W;
`ifdef FIR_ROUND_EN
  localparam logic [ACC_W-1:0] RND = ACC_W'(1 << (SHIFT - 1));
`else
  localparam logic [ACC_W-1:0] RND = '0;
`endif

  logic [NUM_TAPS-1:0][DATA_W-1:0] w_taps;
  logic [PROD_W-1:0]               r_prod [NUM_TAPS];
  logic                            r_v_tap;
  logic                            r_v_prod;
  logic [ACC_W-1:0]                w_acc;
  logic [ACC_W-1:0]                w_shift;

  fir_tap_line #(
    .DATA_W (DATA_W)
  ) u_taps (
    .clock  (clock),
    .i_clr  (reset),
    .i_en   (vin),
    .i_din  (din),
    .o_taps (w_taps)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_v_tap  <= 1'b0;
      r_v_prod <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_prod[k] <= '0;
      end
    end else begin
      r_v_tap  <= vin;
      r_v_prod <= r_v_tap;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_prod[k] <= PROD_W'(w_taps[k]) *
                     PROD_W'(COEF_W'(COEFS[k]));
      end
    end
  end

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      w_acc = w_acc + ACC_W'(r_prod[k]);
    end
  end

  // Coefficients sum to 256, so the shifted result always fits DATA_W.
  assign w_shift = (w_acc + RND) >> SHIFT;

  always_ff @(posedge clock) begin
    if (reset) begin
      vout <= 1'b0;
      dout <= '0;
    end else begin
      vout <= r_v_prod;
      if (r_v_prod) begin
        dout <= DATA_W'(w_shift);
      end
    end
  end
endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter against a queue-based reference model.
module tb_fir_filter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       vin   = 1'b0;
  logic [7:0] din   = '0;
  logic       vout;
  logic [7:0] dout;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  int coef [8] = '{4, 16, 32, 76, 76, 32, 16, 4};
  int hist [8];
  int exp_val [$];
  int exp_due [$];
  int got [$];
`ifdef FIR_ROUND_EN
  int rnd = 128;
  int imp [10] = '{4, 16, 32, 76, 76, 32, 16, 4, 0, 0};
  int rst_first = 4;
`else
  int rnd = 0;
  int imp [10] = '{3, 15, 31, 75, 75, 31, 15, 3, 0, 0};
  int rst_first = 3;
`endif

  fir_filter dut (
    .clock (clock),
    .reset (reset),
    .vin   (vin),
    .din   (din),
    .vout  (vout),
    .dout  (dout)
  );

  always #5 clock = ~clock;

  function automatic int ref_out();
    int s = 0;
    for (int k = 0; k < 8; k++) s += coef[k] * hist[k];
    return (s + rnd) / 256;
  endfunction

  task automatic check(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    bit ev;
    @(posedge clock);
    edge_n++;
    if (reset) begin
      for (int k = 0; k < 8; k++) hist[k] = 0;
      exp_val.delete();
      exp_due.delete();
    end else if (vin) begin
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'(din);
      exp_val.push_back(ref_out());
      exp_due.push_back(edge_n + 2);
    end
    #1;
    ev = (exp_due.size() > 0) && (exp_due[0] == edge_n);
    check("vout", int'(vout), int'(ev));
    if (ev) begin
      check("dout", int'(dout), exp_val[0]);
      void'(exp_val.pop_front());
      void'(exp_due.pop_front());
    end
    if (vout === 1'b1) got.push_back(int'(dout));
  endtask

  task automatic feed(int n, int v);
    vin = 1'b1;
    for (int i = 0; i < n; i++) begin
      din = 8'(v);
      tick();
    end
    vin = 1'b0;
  endtask

  task automatic idle(int n);
    vin = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    check("rst_vout", int'(vout), 0);
    check("rst_dout", int'(dout), 0);
    reset = 1'b0;
    idle(2);

    got.delete();
    feed(1, 255);
    feed(9, 0);
    idle(4);
    check("imp_count", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      check($sformatf("imp[%0d]", i), got[i], imp[i]);

    got.delete();
    feed(12, 100);
    idle(4);
    check("step100_count", got.size(), 12);
    for (int i = 7; i < 12 && i < got.size(); i++)
      check($sformatf("step100[%0d]", i), got[i], 100);

    got.delete();
    feed(12, 255);
    idle(4);
    for (int i = 7; i < 12 && i < got.size(); i++)
      check($sformatf("step255[%0d]", i), got[i], 255);

    do_reset();
    got.delete();
    feed(4, 200);
    idle(20);
    feed(4, 200);
    idle(4);
    check("gap_count", got.size(), 8);
    if (got.size() > 4) check("gap_5th", got[4], 159);

    feed(5, 255);
    vin = 1'b1;
    din = 8'd255;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_vout", int'(vout), 0);
    vin = 1'b0;
    tick();
    check("rst_mid_vout2", int'(vout), 0);
    got.delete();
    feed(1, 255);
    idle(4);
    check("rst_next_count", got.size(), 1);
    if (got.size() > 0) check("rst_next_dout", got[0], rst_first);

    got.delete();
    for (int b = 0; b < 5; b++) begin
      vin = 1'b1;
      for (int i = 0; i < 32; i++) begin
        din = 8'($urandom_range(0, 255));
        tick();
      end
      idle(20);
    end
    check("rand_count", got.size(), 160);
    check("drained", exp_val.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
